rf_alu_arbiter: RTL

Shares the single regfile (2-read/1-write) plus alu16 datapath between two command requesters, e.g. the sequencing FSM and a debug/host port. Each request is one ALU operation on register and/or immediate operands, with optional write-back to the regfile. The block round-robin arbitrates, drives the regfile/ALU control lines for one execute cycle, and returns the result and flags on a valid/ready response channel. It sits between the requesters and the regfile/alu16 pair and replaces the direct FSM-to-datapath wiring.

---
 rtl/rf_alu_arbiter_if.sv | 39 +++
 rtl/rf_alu_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/rf_alu_arbiter_if.sv
// rf_alu_arbiter_if: requester, response and regfile/ALU control bundle for rf_alu_arbiter.
interface rf_alu_arbiter_if #(
    parameter int DW  = 16,
    parameter int AW  = 4,
    parameter int OPW = 5
);
    localparam int CMDW = OPW + 2 + 3 * AW + DW;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [CMDW-1:0] req0_cmd;
    logic [CMDW-1:0] req1_cmd;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [DW-1:0]   rsp_data;
    logic [4:0]      rsp_flags;
    logic [AW-1:0]   rf_ra_addr;
    logic [AW-1:0]   rf_rb_addr;
    logic [AW-1:0]   rf_w_addr;
    logic            rf_we;
    logic [OPW-1:0]  alu_op;
    logic            alu_b_sel;
    logic [DW-1:0]   alu_imm;
    logic [DW-1:0]   alu_y;
    logic [4:0]      alu_flags;
    logic            busy;
    logic [15:0]     op_count;

    modport master (
        output req_valid, req0_cmd, req1_cmd, rsp_ready, alu_y, alu_flags,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
               rf_ra_addr, rf_rb_addr, rf_w_addr, rf_we, alu_op, alu_b_sel, alu_imm, busy, op_count
    );
    modport slave (
        input  req_valid, req0_cmd, req1_cmd, rsp_ready, alu_y, alu_flags,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
               rf_ra_addr, rf_rb_addr, rf_w_addr, rf_we, alu_op, alu_b_sel, alu_imm, busy, op_count
    );
endinterface

// File: rtl/rf_alu_arbiter.sv
// rf_alu_arbiter: round-robin sharing of one regfile/ALU datapath between two command requesters.
module rf_alu_arbiter #(
    parameter int DW  = 16,
    parameter int AW  = 4,
    parameter int OPW = 5
) (
    input logic             clk,
    input logic             rst,
    rf_alu_arbiter_if.slave bus
);
    localparam int CMDW = OPW + 2 + 3 * AW + DW;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t          state_q, state_d;
    logic            last_q, last_d, id_q, id_d;
    logic [CMDW-1:0] cmd_q, cmd_d;
    logic [DW-1:0]   data_q, data_d;
    logic [4:0]      flags_q, flags_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      gnt;
    logic            wb_en;
    logic [AW-1:0]   rd;

    assign {bus.alu_op, wb_en, bus.alu_b_sel, rd, bus.rf_ra_addr, bus.rf_rb_addr, bus.alu_imm} = cmd_q;
    assign bus.rf_w_addr = rd;
    assign bus.rf_we     = (state_q == EXEC) & wb_en & (rd != '0) & ~rst;
    // On a tie the requester that did not win last time is served
    assign gnt[1]        = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
    assign gnt[0]        = bus.req_valid[0] & ~gnt[1];
    assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : 2'b00;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_flags = flags_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.op_count  = cnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = EXEC;
                id_d    = gnt[1];
                last_d  = gnt[1];
                cmd_d   = gnt[1] ? bus.req1_cmd : bus.req0_cmd;
            end
            EXEC: begin
                state_d = RESP;
                data_d  = bus.alu_y;
                flags_d = bus.alu_flags;
            end
            RESP: if (bus.rsp_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cmd_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
